// File: rtl/vdc_ram_sched_if.sv
// Video RAM slot port between the VDC slot scheduler and the RAM.
// The scheduler drives address, write enable and write data; the RAM returns read data.
interface vdc_ram_sched_if #(
    parameter int unsigned AW = 16
);
    logic [AW-1:0] ram_addr;
    logic          ram_we;
    logic [7:0]    ram_di;
    logic [7:0]    ram_do;

    modport master (
        output ram_addr,
        output ram_we,
        output ram_di,
        input  ram_do
    );

    modport slave (
        input  ram_addr,
        input  ram_we,
        input  ram_di,
        output ram_do
    );
endinterface

// File: rtl/vdc_ram_sched.sv
// VDC video RAM slot scheduler: arbitrates display bursts, refresh and CPU/block accesses,
// one RAM slot per enable cycle, and owns the update and copy source addresses.
module vdc_ram_sched #(
    parameter int unsigned AW = 16
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          enable,
    input  logic          lineStart,
    input  logic [3:0]    reg_rfsh,
    input  logic          dispStart,
    input  logic [AW-1:0] dispAddr,
    input  logic [7:0]    dispLen,
    input  logic          addrLoad,
    input  logic [AW-1:0] addrIn,
    input  logic          srcLoad,
    input  logic [AW-1:0] srcIn,
    input  logic          cpuWr,
    input  logic [7:0]    cpuWrData,
    input  logic          cpuRd,
    input  logic          blkStart,
    input  logic [7:0]    blkCount,
    input  logic          blkCopy,
    vdc_ram_sched_if.master ram,
    output logic          dispValid,
    output logic [7:0]    dispData,
    output logic          cpuRdValid,
    output logic [7:0]    cpuRdData,
    output logic [AW-1:0] curAddr,
    output logic [AW-1:0] srcAddr,
    output logic          busy
);

    typedef enum logic [2:0] {
        StIdle, StCpuWr, StCpuRd, StRdWait, StFill, StCopyRd, StCopyLat, StCopyWr
    } state_e;

    localparam logic [AW-1:0] AddrOne = AW'(1);

    state_e        state_q, state_d;
    logic [AW-1:0] cur_q, cur_d;
    logic [AW-1:0] src_q, src_d;
    logic [8:0]    cnt_q, cnt_d;
    logic [7:0]    fill_q, fill_d;
    logic [7:0]    copy_q, copy_d;
    logic [AW-1:0] disp_ptr_q, disp_ptr_d;
    logic [7:0]    disp_rem_q, disp_rem_d;
    logic          disp_lat_q, disp_lat_d;
    logic [3:0]    rfsh_pend_q, rfsh_pend_d;
    logic [7:0]    row_q, row_d;
    logic          disp_valid_q, disp_valid_d;
    logic [7:0]    disp_data_q, disp_data_d;
    logic          cpu_valid_q, cpu_valid_d;
    logic [7:0]    cpu_data_q, cpu_data_d;

    logic          disp_act, rfsh_act, grant;
    logic [AW-1:0] addr_c;
    logic          we_c;
    logic [7:0]    di_c;

    assign disp_act = (disp_rem_q != 8'd0);
    assign rfsh_act = (rfsh_pend_q != 4'd0);
    // The CPU/block machine only owns the slot when neither display nor refresh wants it.
    assign grant    = enable && !disp_act && !rfsh_act;

    always_comb begin
        state_d      = state_q;
        cur_d        = cur_q;
        src_d        = src_q;
        cnt_d        = cnt_q;
        fill_d       = fill_q;
        copy_d       = copy_q;
        disp_ptr_d   = disp_ptr_q;
        disp_rem_d   = disp_rem_q;
        disp_lat_d   = disp_lat_q;
        rfsh_pend_d  = rfsh_pend_q;
        row_d        = row_q;
        disp_valid_d = 1'b0;
        disp_data_d  = disp_data_q;
        cpu_valid_d  = 1'b0;
        cpu_data_d   = cpu_data_q;
        addr_c       = {{(AW-8){1'b0}}, row_q};
        we_c         = 1'b0;
        di_c         = 8'd0;

        if (enable) begin
            if (disp_lat_q) begin
                disp_data_d  = ram.ram_do;
                disp_valid_d = 1'b1;
            end
            disp_lat_d = disp_act;
            if (disp_act) begin
                addr_c     = disp_ptr_q;
                disp_ptr_d = disp_ptr_q + AddrOne;
                disp_rem_d = disp_rem_q - 8'd1;
            end else if (rfsh_act) begin
                row_d       = row_q + 8'd1;
                rfsh_pend_d = rfsh_pend_q - 4'd1;
            end
            if (lineStart) begin
                rfsh_pend_d = reg_rfsh;
            end
        end

        if (dispStart) begin
            disp_ptr_d = dispAddr;
            disp_rem_d = dispLen;
        end

        case (state_q)
            StIdle: begin
                if (addrLoad) cur_d = addrIn;
                if (srcLoad)  src_d = srcIn;
                if (cpuWr) begin
                    fill_d  = cpuWrData;
                    state_d = StCpuWr;
                end else if (cpuRd) begin
                    state_d = StCpuRd;
                end else if (blkStart) begin
                    cnt_d   = (blkCount == 8'd0) ? 9'd256 : {1'b0, blkCount};
                    state_d = blkCopy ? StCopyRd : StFill;
                end
            end
            StCpuWr: begin
                if (grant) begin
                    addr_c  = cur_q;
                    we_c    = 1'b1;
                    di_c    = fill_q;
                    cur_d   = cur_q + AddrOne;
                    state_d = StIdle;
                end
            end
            StCpuRd: begin
                if (grant) begin
                    addr_c  = cur_q;
                    cur_d   = cur_q + AddrOne;
                    state_d = StRdWait;
                end
            end
            StRdWait: begin
                if (enable) begin
                    cpu_data_d  = ram.ram_do;
                    cpu_valid_d = 1'b1;
                    state_d     = StIdle;
                end
            end
            StFill: begin
                if (grant) begin
                    addr_c = cur_q;
                    we_c   = 1'b1;
                    di_c   = fill_q;
                    cur_d  = cur_q + AddrOne;
                    cnt_d  = cnt_q - 9'd1;
                    if (cnt_q == 9'd1) state_d = StIdle;
                end
            end
            StCopyRd: begin
                if (grant) begin
                    addr_c  = src_q;
                    src_d   = src_q + AddrOne;
                    state_d = StCopyLat;
                end
            end
            StCopyLat: begin
                if (enable) begin
                    copy_d  = ram.ram_do;
                    state_d = StCopyWr;
                end
            end
            StCopyWr: begin
                if (grant) begin
                    addr_c  = cur_q;
                    we_c    = 1'b1;
                    di_c    = copy_q;
                    cur_d   = cur_q + AddrOne;
                    cnt_d   = cnt_q - 9'd1;
                    state_d = (cnt_q == 9'd1) ? StIdle : StCopyRd;
                end
            end
            default: state_d = StIdle;
        endcase

        // No write may reach the RAM in the cycle that abandons an operation.
        if (reset) we_c = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= StIdle;
            cur_q        <= '0;
            src_q        <= '0;
            cnt_q        <= '0;
            fill_q       <= '0;
            copy_q       <= '0;
            disp_ptr_q   <= '0;
            disp_rem_q   <= '0;
            disp_lat_q   <= 1'b0;
            rfsh_pend_q  <= '0;
            row_q        <= '0;
            disp_valid_q <= 1'b0;
            disp_data_q  <= '0;
            cpu_valid_q  <= 1'b0;
            cpu_data_q   <= '0;
        end else begin
            state_q      <= state_d;
            cur_q        <= cur_d;
            src_q        <= src_d;
            cnt_q        <= cnt_d;
            fill_q       <= fill_d;
            copy_q       <= copy_d;
            disp_ptr_q   <= disp_ptr_d;
            disp_rem_q   <= disp_rem_d;
            disp_lat_q   <= disp_lat_d;
            rfsh_pend_q  <= rfsh_pend_d;
            row_q        <= row_d;
            disp_valid_q <= disp_valid_d;
            disp_data_q  <= disp_data_d;
            cpu_valid_q  <= cpu_valid_d;
            cpu_data_q   <= cpu_data_d;
        end
    end

    assign ram.ram_addr = addr_c;
    assign ram.ram_we   = we_c;
    assign ram.ram_di   = di_c;
    assign dispValid    = disp_valid_q;
    assign dispData     = disp_data_q;
    assign cpuRdValid   = cpu_valid_q;
    assign cpuRdData    = cpu_data_q;
    assign curAddr      = cur_q;
    assign srcAddr      = src_q;
    assign busy         = (state_q != StIdle);

endmodule

// File: tb/tb_vdc_ram_sched.sv
// Scoreboard bench for vdc_ram_sched: directed stimulus queues expected RAM writes and read
// returns, a forked monitor compares them as the DUT presents them.
module tb_vdc_ram_sched;
    localparam int unsigned AW = 16;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          enable = 1'b1;
    logic          lineStart = 1'b0;
    logic [3:0]    reg_rfsh = 4'd0;
    logic          dispStart = 1'b0;
    logic [AW-1:0] dispAddr = '0;
    logic [7:0]    dispLen = 8'd0;
    logic          addrLoad = 1'b0;
    logic [AW-1:0] addrIn = '0;
    logic          srcLoad = 1'b0;
    logic [AW-1:0] srcIn = '0;
    logic          cpuWr = 1'b0;
    logic [7:0]    cpuWrData = 8'd0;
    logic          cpuRd = 1'b0;
    logic          blkStart = 1'b0;
    logic [7:0]    blkCount = 8'd0;
    logic          blkCopy = 1'b0;
    logic          dispValid;
    logic [7:0]    dispData;
    logic          cpuRdValid;
    logic [7:0]    cpuRdData;
    logic [AW-1:0] curAddr;
    logic [AW-1:0] srcAddr;
    logic          busy;

    always #5 clk = ~clk;

    vdc_ram_sched_if #(.AW(AW)) ram_bus ();

    vdc_ram_sched #(.AW(AW)) dut (
        .clk        (clk),
        .reset      (reset),
        .enable     (enable),
        .lineStart  (lineStart),
        .reg_rfsh   (reg_rfsh),
        .dispStart  (dispStart),
        .dispAddr   (dispAddr),
        .dispLen    (dispLen),
        .addrLoad   (addrLoad),
        .addrIn     (addrIn),
        .srcLoad    (srcLoad),
        .srcIn      (srcIn),
        .cpuWr      (cpuWr),
        .cpuWrData  (cpuWrData),
        .cpuRd      (cpuRd),
        .blkStart   (blkStart),
        .blkCount   (blkCount),
        .blkCopy    (blkCopy),
        .ram        (ram_bus.master),
        .dispValid  (dispValid),
        .dispData   (dispData),
        .cpuRdValid (cpuRdValid),
        .cpuRdData  (cpuRdData),
        .curAddr    (curAddr),
        .srcAddr    (srcAddr),
        .busy       (busy)
    );

    // Unwritten locations read back as a fixed function of their address.
    function automatic logic [7:0] pat(input logic [15:0] a);
        return a[7:0] ^ a[15:8] ^ 8'hA5;
    endfunction

    logic [7:0] mem [0:65535];
    bit         wr_mark [0:65535];
    logic [7:0] rdo = 8'd0;

    always @(posedge clk) begin
        if (enable) begin
            if (ram_bus.ram_we) begin
                mem[ram_bus.ram_addr]     <= ram_bus.ram_di;
                wr_mark[ram_bus.ram_addr] <= 1'b1;
            end else begin
                rdo <= wr_mark[ram_bus.ram_addr] ? mem[ram_bus.ram_addr]
                                                 : pat(ram_bus.ram_addr);
            end
        end
    end
    assign ram_bus.ram_do = rdo;

    typedef struct packed {
        logic [15:0] addr;
        logic [7:0]  data;
        int          min_disp;
    } wr_t;

    wr_t        wr_q[$];
    logic [7:0] disp_q[$];
    logic [7:0] cpu_q[$];
    int         n_vec = 0;
    int         n_err = 0;
    int         disp_seen = 0;
    bit         ignore_wr = 1'b0;
    bit         forbid_wr = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic fail_evt(input string name);
        n_vec++;
        n_err++;
        $display("FAIL %s: unexpected event at %0t", name, $time);
    endtask

    task automatic monitor();
        wr_t w;
        logic [7:0] e;
        forever begin
            @(negedge clk);
            if (dispValid) begin
                if (disp_q.size() == 0) fail_evt("disp_unexpected");
                else begin
                    e = disp_q.pop_front();
                    chk("disp_data", dispData, e);
                end
                disp_seen++;
            end
            if (cpuRdValid) begin
                if (cpu_q.size() == 0) fail_evt("cpurd_unexpected");
                else begin
                    e = cpu_q.pop_front();
                    chk("cpurd_data", cpuRdData, e);
                end
            end
            if (forbid_wr) begin
                chk("no_write_after_reset", enable && ram_bus.ram_we, 0);
            end else if (enable && ram_bus.ram_we && !ignore_wr) begin
                if (wr_q.size() == 0) fail_evt("write_unexpected");
                else begin
                    w = wr_q.pop_front();
                    chk("wr_addr", ram_bus.ram_addr, w.addr);
                    chk("wr_data", ram_bus.ram_di, w.data);
                    chk("wr_after_disp", disp_seen >= w.min_disp, 1);
                end
            end
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_idle(input int max, input string name);
        int n = 0;
        while (busy && n < max) begin
            @(negedge clk);
            n++;
        end
        if (busy) fail_evt(name);
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int bc;
        int n;
        fork
            monitor();
        join_none

        // Reset state
        repeat (3) tick();
        @(negedge clk);
        chk("rst_busy", busy, 0);
        chk("rst_curAddr", curAddr, 0);
        chk("rst_srcAddr", srcAddr, 0);
        chk("rst_ram_we", ram_bus.ram_we, 0);
        chk("rst_ram_addr", ram_bus.ram_addr, 0);
        chk("rst_dispValid", dispValid, 0);
        chk("rst_cpuRdValid", cpuRdValid, 0);
        tick();
        reset = 1'b0;
        tick();

        // Single CPU write
        addrIn = 16'h1000; addrLoad = 1'b1; tick(); addrLoad = 1'b0;
        cpuWrData = 8'h5A;
        wr_q.push_back('{16'h1000, 8'h5A, 0});
        cpuWr = 1'b1; tick(); cpuWr = 1'b0;
        bc = 0;
        repeat (4) begin
            @(negedge clk);
            if (busy) bc++;
        end
        chk("cpuwr_busy_cycles", bc, 1);
        chk("cpuwr_curAddr", curAddr, 16'h1001);
        tick();

        // Same-cycle addrLoad + cpuWr, then 256-word fill across the wrap
        addrIn = 16'hFFFF; addrLoad = 1'b1; cpuWrData = 8'h11; cpuWr = 1'b1;
        wr_q.push_back('{16'hFFFF, 8'h11, 0});
        tick(); addrLoad = 1'b0; cpuWr = 1'b0;
        wait_idle(10, "cpuwr2_timeout");
        tick();
        blkCount = 8'd0; blkCopy = 1'b0; blkStart = 1'b1;
        for (int i = 0; i < 256; i++) wr_q.push_back('{16'(i), 8'h11, 0});
        tick(); blkStart = 1'b0;
        wait_idle(400, "fill256_timeout");
        chk("fill256_curAddr", curAddr, 16'h0100);
        tick();

        // Block copy of 3 words
        srcIn = 16'h2000; srcLoad = 1'b1; addrIn = 16'h3000; addrLoad = 1'b1;
        tick(); srcLoad = 1'b0; addrLoad = 1'b0;
        blkCount = 8'd3; blkCopy = 1'b1; blkStart = 1'b1;
        for (int i = 0; i < 3; i++) wr_q.push_back('{16'h3000 + 16'(i), pat(16'h2000 + 16'(i)), 0});
        tick(); blkStart = 1'b0;
        wait_idle(50, "copy_timeout");
        chk("copy_srcAddr", srcAddr, 16'h2003);
        chk("copy_curAddr", curAddr, 16'h3003);
        tick();

        // CPU read of a copied word
        addrIn = 16'h3001; addrLoad = 1'b1; cpuRd = 1'b1;
        cpu_q.push_back(pat(16'h2001));
        tick(); addrLoad = 1'b0; cpuRd = 1'b0;
        wait_idle(10, "cpurd_timeout");
        tick(); tick();
        chk("cpurd_curAddr", curAddr, 16'h3002);

        // Display burst pre-empts a fill that repeats the last CPU write byte
        addrIn = 16'h4000; addrLoad = 1'b1; cpuWrData = 8'h77; cpuWr = 1'b1;
        wr_q.push_back('{16'h4000, 8'h77, 0});
        tick(); addrLoad = 1'b0; cpuWr = 1'b0;
        wait_idle(10, "cpuwr3_timeout");
        tick();
        dispAddr = 16'h0800; dispLen = 8'd80; dispStart = 1'b1;
        blkCount = 8'd10; blkCopy = 1'b0; blkStart = 1'b1;
        for (int i = 0; i < 80; i++) disp_q.push_back(pat(16'h0800 + 16'(i)));
        for (int i = 0; i < 10; i++) wr_q.push_back('{16'h4001 + 16'(i), 8'h77, 79});
        tick(); dispStart = 1'b0; blkStart = 1'b0;
        wait_idle(200, "dispfill_timeout");
        n = 0;
        while (disp_q.size() != 0 && n < 10) begin
            @(negedge clk);
            n++;
        end
        chk("disp_all_seen", disp_q.size(), 0);
        chk("dispfill_curAddr", curAddr, 16'h400B);
        tick();

        // Refresh rows, continuing across lines
        @(negedge clk);
        chk("idle_row0", ram_bus.ram_addr, 0);
        tick();
        reg_rfsh = 4'd5; lineStart = 1'b1; tick(); lineStart = 1'b0;
        for (int r = 0; r < 5; r++) begin
            @(negedge clk);
            chk("rfsh_row_l1", ram_bus.ram_addr, r);
        end
        @(negedge clk);
        chk("rfsh_idle_l1", ram_bus.ram_addr, 5);
        tick();
        lineStart = 1'b1; tick(); lineStart = 1'b0;
        for (int r = 5; r < 10; r++) begin
            @(negedge clk);
            chk("rfsh_row_l2", ram_bus.ram_addr, r);
        end
        @(negedge clk);
        chk("rfsh_idle_l2", ram_bus.ram_addr, 10);
        tick();

        // A new line discards the unserved refresh remainder
        reg_rfsh = 4'd3; lineStart = 1'b1; tick();
        reg_rfsh = 4'd2;
        @(negedge clk);
        chk("rfsh_row_l3", ram_bus.ram_addr, 10);
        tick(); lineStart = 1'b0;
        for (int r = 11; r < 13; r++) begin
            @(negedge clk);
            chk("rfsh_row_l4", ram_bus.ram_addr, r);
        end
        repeat (2) begin
            @(negedge clk);
            chk("rfsh_idle_l4", ram_bus.ram_addr, 13);
        end
        tick();

        // Strobes captured with enable low; the write waits for a slot
        enable = 1'b0;
        addrIn = 16'h5000; addrLoad = 1'b1; cpuWrData = 8'h3C; cpuWr = 1'b1;
        wr_q.push_back('{16'h5000, 8'h3C, 0});
        tick(); addrLoad = 1'b0; cpuWr = 1'b0;
        bc = 0;
        repeat (3) begin
            @(negedge clk);
            if (busy) bc++;
        end
        chk("stall_busy_cycles", bc, 3);
        chk("stall_curAddr", curAddr, 16'h5000);
        tick();
        enable = 1'b1;
        wait_idle(10, "stall_timeout");
        chk("stall_done_curAddr", curAddr, 16'h5001);
        tick();

        // Reset in the middle of a 100-word copy
        addrIn = 16'h6000; addrLoad = 1'b1; srcIn = 16'h7000; srcLoad = 1'b1;
        tick(); addrLoad = 1'b0; srcLoad = 1'b0;
        ignore_wr = 1'b1;
        blkCount = 8'd100; blkCopy = 1'b1; blkStart = 1'b1;
        tick(); blkStart = 1'b0;
        repeat (30) tick();
        chk("midcopy_busy", busy, 1);
        reset = 1'b1; forbid_wr = 1'b1;
        tick();
        reset = 1'b0;
        chk("postrst_busy", busy, 0);
        chk("postrst_curAddr", curAddr, 0);
        chk("postrst_srcAddr", srcAddr, 0);
        repeat (20) tick();
        forbid_wr = 1'b0;
        ignore_wr = 1'b0;

        repeat (3) tick();
        chk("wr_queue_empty", wr_q.size(), 0);
        chk("disp_queue_empty", disp_q.size(), 0);
        chk("cpu_queue_empty", cpu_q.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule

// File: doc/vdc_ram_sched.md
Name: vdc_ram_sched

Overview:
- Slot scheduler for the VDC video RAM. One RAM access ("slot") is granted per `enable` cycle.
- Requesters: display fetch bursts (issued by the row/line fetch logic after fetchRow/fetchLine), DRAM refresh, single CPU reads/writes through the R31 data port, and block fill/copy (R30/R24[7]/R32-33).
- Owns the update address (R18/19) and the block-copy source address (R32/33), and generates the status busy bit.

Parameters:
- AW, 16, RAM address width; all address arithmetic wraps modulo 2^AW.

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high reset
- enable  in  1  slot strobe; one RAM slot per asserted cycle
- lineStart  in  1  start of scanline (sampled only with enable)
- reg_rfsh  in  4  R36[3:0], refresh slots per line
- dispStart  in  1  start a display read burst
- dispAddr  in  AW  burst start address
- dispLen  in  8  burst word count; 0 = no burst
- addrLoad  in  1  load update address
- addrIn  in  AW  R18/19 value
- srcLoad  in  1  load copy source address
- srcIn  in  AW  R32/33 value
- cpuWr  in  1  R31 write strobe
- cpuWrData  in  8  R31 write data
- cpuRd  in  1  R31 read request
- blkStart  in  1  R30 write strobe
- blkCount  in  8  word count; 0 = 256
- blkCopy  in  1  R24[7]: 1 = copy, 0 = fill
- ram_do  in  8  RAM read data, valid one slot after a read
- ram_addr  out  AW  slot address
- ram_we  out  1  slot write enable
- ram_di  out  8  slot write data
- dispValid  out  1  one-clk pulse: dispData valid
- dispData  out  8  display word
- cpuRdValid  out  1  one-clk pulse: cpuRdData updated
- cpuRdData  out  8  last CPU read word
- curAddr  out  AW  update address
- srcAddr  out  AW  copy source address
- busy  out  1  CPU/block operation pending

Behaviour:
- Reset values:
  - all outputs 0; curAddr = srcAddr = 0; state IDLE
  - burst, refresh and fill registers cleared; refresh row counter = 0
  - reset mid-operation abandons it with no further RAM writes.
- Timing base: all state advances only on enable, except that strobes (dispStart, addrLoad, srcLoad, cpuWr, cpuRd, blkStart) are captured on any clk.
- Slot priority each enable cycle, fixed:
  1. display burst
  2. refresh
  3. CPU/block state machine
  4. otherwise idle: ram_we = 0, ram_addr = refresh row counter.
- Display burst:
  - dispStart loads pointer = dispAddr, remaining = dispLen.
  - One read per slot while remaining ≠ 0; pointer increments, remaining decrements.
  - dispStart during an active burst restarts the burst.
- Read latency: ram_do is sampled on the next enable cycle after a read slot.
  - Display read: dispData = ram_do, dispValid pulse.
  - CPU read: cpuRdData = ram_do, cpuRdValid pulse.
- Refresh:
  - An enabled lineStart loads pending = reg_rfsh, discarding any unserved remainder.
  - Each refresh slot: read at {0, row counter[7:0]}, row counter increments mod 256, pending decrements, data discarded.
- busy = (state ≠ IDLE). cpuWr, cpuRd and blkStart while busy are ignored.
- addrLoad/srcLoad while busy are ignored; they are accepted in IDLE. addrLoad has priority over a same-cycle cpuWr/cpuRd, which then uses addrIn.
- State machine:
  - IDLE:
    - cpuWr → CPU_WR, latch fillData = cpuWrData.
    - cpuRd → CPU_RD.
    - blkStart → FILL or COPY_RD per blkCopy; cnt = blkCount (0 → 256).
    - Simultaneous strobes: priority cpuWr > cpuRd > blkStart.
  - CPU_WR, on granted slot: write fillData at curAddr; curAddr+1; → IDLE.
  - CPU_RD, on granted slot: read curAddr; curAddr+1; → RD_WAIT.
  - RD_WAIT: next enable cycle captures data → IDLE.
  - FILL, per granted slot: write fillData at curAddr; curAddr+1; cnt−1; cnt reaches 0 → IDLE.
  - COPY_RD, on granted slot: read srcAddr; srcAddr+1; → COPY_LAT.
  - COPY_LAT: next enable cycle latches ram_do into copyData → COPY_WR.
  - COPY_WR, on granted slot: write copyData at curAddr; curAddr+1; cnt−1; then → COPY_RD, or IDLE when cnt reaches 0.
- Ungranted slots stall the state machine without loss.
- Address increments wrap from 2^AW−1 to 0.
- fillData persists, so a fill after a CPU write repeats that byte.

Test Plan:
- cpuWr data 0x5A with curAddr = 0x1000, no other traffic → one write slot at 0x1000, data 0x5A; curAddr = 0x1001; busy high for exactly one enable cycle.
- addrLoad 0xFFFF, cpuWr 0x11, then blkStart count 0 with blkCopy = 0 → 257 writes of 0x11 at 0xFFFF, 0x0000 … 0x00FF; curAddr ends at 0x0100.
- srcLoad 0x2000, curAddr 0x3000, preloaded RAM, blkStart count 3 with blkCopy = 1 → reads 0x2000–0x2002 and writes 0x3000–0x3002 with matching data; each write comes at least 2 slots after its read.
- dispStart addr 0x0800, len 80 concurrent with a fill of 10 words → 80 consecutive display reads, fill stalls, dispValid pulses 80 times in order, then fill completes.
- lineStart with reg_rfsh = 5, no bursts → 5 refresh reads at rows 0–4; next line continues from row 5.
- Reset asserted mid-copy (cnt = 100) → no further ram_we; busy = 0; curAddr = srcAddr = 0 the next cycle.
